// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift/add-3 step per clock.
// Define BCD_BLANK_EN to add per-digit leading-zero blank flags on port blank.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd
`ifdef BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]   blank
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t              state_r, state_s;
   logic [WIDTH-1:0]    shift_r, shift_s;
   logic [BW-1:0]       work_r,  work_s;
   logic [CW-1:0]       cnt_r,   cnt_s;
   logic                busy_r,  busy_s;
   logic                done_r,  done_s;
   logic [BW-1:0]       bcd_r,   bcd_s;
   logic [BW+WIDTH-1:0] step_s;
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0]   blank_r, blank_s;
`endif

   // Valid digits are 0..9, so a 4-bit add without carry-out is sufficient.
   function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] w);
      logic [BW-1:0] r;
      r = w;
      for (int i = 0; i < DIGITS; i++) begin
         if (w[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = w[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = w[4*i +: 4];
         end
      end
      return r;
   endfunction

`ifdef BCD_BLANK_EN
   // Digit 0 is never blanked so a zero result still shows a single "0".
   function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] w);
      logic [DIGITS-1:0] b;
      logic              upper_zero;
      b          = {DIGITS{1'b0}};
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (w[4*i +: 4] == 4'd0);
         b[i]       = upper_zero;
      end
      return b;
   endfunction
`endif

   // Next-state and datapath step; bcd only moves on the final step.
   always_comb begin
      state_s = state_r;
      shift_s = shift_r;
      work_s  = work_r;
      cnt_s   = cnt_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      bcd_s   = bcd_r;
`ifdef BCD_BLANK_EN
      blank_s = blank_r;
`endif
      step_s  = {add3_all(work_r), shift_r} << 1'b1;
      case (state_r)
         IDLE: begin
            if (start) begin
               shift_s = bin;
               work_s  = {BW{1'b0}};
               cnt_s   = CW'(WIDTH);
               busy_s  = 1'b1;
               state_s = CONV;
            end else begin
               busy_s  = 1'b0;
            end
         end
         CONV: begin
            work_s  = step_s[BW+WIDTH-1:WIDTH];
            shift_s = step_s[WIDTH-1:0];
            cnt_s   = cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
               bcd_s   = step_s[BW+WIDTH-1:WIDTH];
`ifdef BCD_BLANK_EN
               blank_s = blank_of(step_s[BW+WIDTH-1:WIDTH]);
`endif
               done_s  = 1'b1;
               busy_s  = 1'b0;
               state_s = IDLE;
            end else begin
               busy_s  = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any conversion immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         shift_r <= {WIDTH{1'b0}};
         work_r  <= {BW{1'b0}};
         cnt_r   <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         bcd_r   <= {BW{1'b0}};
`ifdef BCD_BLANK_EN
         blank_r <= {DIGITS{1'b0}};
`endif
      end else begin
         state_r <= state_s;
         shift_r <= shift_s;
         work_r  <= work_s;
         cnt_r   <= cnt_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         bcd_r   <= bcd_s;
`ifdef BCD_BLANK_EN
         blank_r <= blank_s;
`endif
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign bcd  = bcd_r;
`ifdef BCD_BLANK_EN
   assign blank = blank_r;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against an arithmetic decimal model.
// Covers latency, back-to-back starts, ignored starts, async reset abort and a full sweep.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
`ifdef BCD_BLANK_EN
   logic [2:0]  blank;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [11:0] prev_bcd;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
`ifdef BCD_BLANK_EN
      .blank (blank),
`endif
      .bcd   (bcd)
   );

   // Reference: decimal digits by division, independent of the shift/add-3 method.
   function automatic logic [11:0] dec_of(input int v);
      logic [11:0] r;
      int          p;
      r = 12'd0;
      p = 1;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [2:0] blank_model(input int v);
      logic [2:0] b;
      b    = 3'b000;
      b[1] = (v < 10);
      b[2] = (v < 100);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start a conversion on the next edge and check every cycle up to the done pulse.
   task automatic conv(input int v, input bit hold, input string tag);
      bin   = 8'(v);
      start = 1'b1;
      step();
      if (!hold) start = 1'b0;
      bin = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step();
         chk({tag, "_busy"},   32'(busy), 32'd1);
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         chk({tag, "_hold"},   32'(bcd),  32'(prev_bcd));
      end
      step();
      chk({tag, "_done"},  32'(done), 32'd1);
      chk({tag, "_idle"},  32'(busy), 32'd0);
      chk({tag, "_bcd"},   32'(bcd),  32'(dec_of(v)));
`ifdef BCD_BLANK_EN
      chk({tag, "_blank"}, 32'(blank), 32'(blank_model(v)));
`endif
      prev_bcd = dec_of(v);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      bin      = 8'd0;
      prev_bcd = 12'd0;
      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd",  32'(bcd),  32'd0);
`ifdef BCD_BLANK_EN
      chk("rst_blank", 32'(blank), 32'd0);
`endif
      rst = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 32'd0);

      conv(255, 1'b0, "c255");
      conv(0,   1'b0, "b2b0");
      conv(99,  1'b0, "b2b99");
      conv(7,   1'b0, "b2b7");

      // Start pulsed mid-conversion must be ignored.
      bin   = 8'd128;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      bin   = 8'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      for (int i = 4; i < 8; i++) begin
         step();
         chk("ign_busy", 32'(busy), 32'd1);
         chk("ign_nodone", 32'(done), 32'd0);
      end
      step();
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_bcd",  32'(bcd),  32'(dec_of(128)));
      prev_bcd = dec_of(128);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("ign_no2nd", 32'(done), 32'd0);
         chk("ign_nobusy", 32'(busy), 32'd0);
      end

      // Asynchronous reset in the middle of a conversion.
      bin   = 8'd200;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_bcd",  32'(bcd),  32'd0);
`ifdef BCD_BLANK_EN
      chk("arst_blank", 32'(blank), 32'd0);
`endif
      #2 rst = 1'b0;
      prev_bcd = 12'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("arst_nodone", 32'(done), 32'd0);
         chk("arst_nobusy", 32'(busy), 32'd0);
      end
      conv(42, 1'b0, "c42");

      conv(255, 1'b0, "pre255");
      conv(10,  1'b0, "c10");

      // Start held high: each conversion is accepted on the previous done cycle.
      for (int v = 0; v < 256; v++) begin
         conv(v, 1'b1, "sweep");
      end
      start = 1'b0;

      for (int i = 0; i < 20; i++) begin
         conv(int'($urandom_range(255, 0)), 1'b0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
